// File: rtl/apu_pkg.sv
// Shared definitions for the APU serial link (encoder and decoder side).
// Holds the frame geometry constants, the serialiser FSM state type and a
// helper that packs an address/data pair into the word shifted out LSB first.
package apu_pkg;

    localparam int unsigned APU_ADDR_W = 3;
    localparam int unsigned APU_DATA_W = 8;
    localparam int unsigned WORD_W     = APU_ADDR_W + APU_DATA_W;
    // start + address + data + stop
    localparam int unsigned FRAME_BITS = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2,
        GAP   = 2'd3
    } apu_state_e;

    // Address occupies the low bits so it leaves the shifter first.
    function automatic logic [WORD_W-1:0] apu_pack(input logic [APU_ADDR_W-1:0] addr,
                                                   input logic [APU_DATA_W-1:0] data);
        return {data, addr};
    endfunction

endpackage

// File: rtl/apu_fifo.sv
// Synchronous show-ahead FIFO buffering APU register writes.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   - write request; ignored while full
//   pop               - consume the head entry; ignored while empty
//   pop_data          - head entry, valid whenever empty is low
//   full, empty       - occupancy flags, derived from the registered count
module apu_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == COUNT_FULL);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/apu_encoder.sv
// APU register-write serialiser. Buffers (addr, data) writes and sends each as a
// 13-bit frame (start 0, addr LSB first, data LSB first, stop 1) followed by one
// idle bit, over a continuously running sck/sdi pair.
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   wr_valid, wr_ready - write handshake; wr_ready is simply "FIFO not full"
//   wr_addr, wr_data   - APU register index and value
//   sck                - bit clock, low for the first half of each bit period
//   sdi                - serial data, changes only when sck falls
//   busy               - FIFO non-empty or a frame still on the wire
module apu_encoder
    import apu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [APU_ADDR_W-1:0] wr_addr,
    input  logic [APU_DATA_W-1:0] wr_data,
    output logic                  sck,
    output logic                  sdi,
    output logic                  busy
);

    localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2);
    localparam logic [3:0]       BITS_LAST = 4'(WORD_W);

    logic [DIV_W-1:0]  div_q;
    apu_state_e        state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [3:0]        bit_cnt_q;
    logic              sdi_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_word;
    logic              bit_end;

    // Decisions are taken on the last cycle of a bit period so that the
    // registered sdi changes exactly on the following bit-boundary cycle.
    assign bit_end   = (div_q == DIV_LAST);
    assign fifo_push = wr_valid && !fifo_full && !rst;
    assign fifo_pop  = bit_end && !fifo_empty && !rst &&
                       ((state_q == IDLE) || (state_q == GAP));

    assign wr_ready = !fifo_full;
    assign sck      = (div_q >= DIV_HALF);
    assign sdi      = sdi_q;
    assign busy     = !fifo_empty || (state_q != IDLE);

    apu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (apu_pack(wr_addr, wr_data)),
        .pop       (fifo_pop),
        .pop_data  (fifo_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sdi_q     <= 1'b1;
        end else begin
            div_q <= bit_end ? '0 : div_q + 1'b1;
            if (bit_end) begin
                unique case (state_q)
                    IDLE, GAP: begin
                        if (!fifo_empty) begin
                            sdi_q     <= 1'b0;
                            shreg_q   <= fifo_word;
                            bit_cnt_q <= '0;
                            state_q   <= SHIFT;
                        end else begin
                            sdi_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt_q == BITS_LAST) begin
                            sdi_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            sdi_q     <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    STOP: begin
                        sdi_q   <= 1'b1;
                        state_q <= GAP;
                    end
                    default: begin
                        sdi_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
